// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control unit and the ALU control decoder.
// Holds state enum, opcode/funct constants, alu_op classes and datapath mux selects.
package mips_ctrl_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned FN_W    = 6;
   localparam int unsigned ALUOP_W = 4;
   localparam int unsigned SEL_W   = 2;
   localparam int unsigned STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_R_EXEC    = 4'd3,
      S_R_WB      = 4'd4,
      S_JR        = 4'd5,
      S_MEM_ADDR  = 4'd6,
      S_MEM_READ  = 4'd7,
      S_MEM_WRITE = 4'd8,
      S_MEM_WB    = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11,
      S_I_EXEC    = 4'd12,
      S_I_WB      = 4'd13
   } state_t;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
   localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
   localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
   localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   localparam logic [FN_W-1:0] FN_JR    = 6'h08;

   localparam logic [ALUOP_W-1:0] ALU_RTYPE  = 4'd0;
   localparam logic [ALUOP_W-1:0] ALU_LW_SW  = 4'd1;
   localparam logic [ALUOP_W-1:0] ALU_BRANCH = 4'd2;
   localparam logic [ALUOP_W-1:0] ALU_AND    = 4'd3;
   localparam logic [ALUOP_W-1:0] ALU_OR     = 4'd4;
   localparam logic [ALUOP_W-1:0] ALU_XOR    = 4'd5;
   localparam logic [ALUOP_W-1:0] ALU_SLT    = 4'd6;
   localparam logic [ALUOP_W-1:0] ALU_SLTU   = 4'd7;
   localparam logic [ALUOP_W-1:0] ALU_LUI    = 4'd8;

   localparam logic [SEL_W-1:0] ALUB_REG  = 2'b00;
   localparam logic [SEL_W-1:0] ALUB_FOUR = 2'b01;
   localparam logic [SEL_W-1:0] ALUB_IMM  = 2'b10;
   localparam logic [SEL_W-1:0] ALUB_BOFF = 2'b11;

   localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
   localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [SEL_W-1:0] PCSRC_REGA   = 2'b11;

   // Immediate-ALU group occupies opcodes 0x08..0x0F.
   function automatic logic is_itype(input logic [OP_W-1:0] op);
      return op[5:3] == 3'b001;
   endfunction

   function automatic logic is_legal(input logic [OP_W-1:0] op);
      return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) || (op == OP_BNE) ||
             (op == OP_LW) || (op == OP_SW) || is_itype(op);
   endfunction

   function automatic logic [ALUOP_W-1:0] itype_alu_op(input logic [OP_W-1:0] op);
      logic [ALUOP_W-1:0] r;
      r = ALU_LW_SW;
      case (op)
         OP_SLTI:  r = ALU_SLT;
         OP_SLTIU: r = ALU_SLTU;
         OP_ANDI:  r = ALU_AND;
         OP_ORI:   r = ALU_OR;
         OP_XORI:  r = ALU_XOR;
         OP_LUI:   r = ALU_LUI;
         default:  r = ALU_LW_SW;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ctrl_multiciclo.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back
// and decodes datapath selects, strobes and ALUOp from the current state.
module ctrl_multiciclo
   import mips_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [OP_W-1:0]    opcode,
   input  logic [FN_W-1:0]    funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               branch_ne,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [SEL_W-1:0]   alu_src_b,
   output logic               imm_zero,
   output logic [SEL_W-1:0]   pc_source,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               illegal_op
);

   state_t r_state;
   state_t w_next;
   logic   r_bne_q;
   logic   w_unused;

   // The branch condition is resolved in the datapath; zero is not needed here.
   assign w_unused = zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_bne_q <= 1'b0;
      else if ((r_state == S_DECODE) && ((opcode == OP_BEQ) || (opcode == OP_BNE)))
         r_bne_q <= (opcode == OP_BNE);
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = S_FETCH;
         S_FETCH:  if (mem_ready) w_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:       w_next = S_R_EXEC;
               OP_LW, OP_SW:   w_next = S_MEM_ADDR;
               OP_BEQ, OP_BNE: w_next = S_BRANCH;
               OP_J:           w_next = S_JUMP;
               default:        w_next = is_itype(opcode) ? S_I_EXEC : S_FETCH;
            endcase
         end
         S_R_EXEC:    w_next = (funct == FN_JR) ? S_JR : S_R_WB;
         S_MEM_ADDR:  w_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  if (mem_ready) w_next = S_MEM_WB;
         S_MEM_WRITE: if (mem_ready) w_next = S_FETCH;
         S_I_EXEC:    w_next = S_I_WB;
         S_R_WB, S_JR, S_MEM_WB, S_BRANCH, S_JUMP, S_I_WB:
                      w_next = S_FETCH;
         default:     w_next = S_IDLE;
      endcase
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = ALUB_REG;
      imm_zero      = 1'b0;
      pc_source     = PCSRC_ALU;
      alu_op        = ALU_RTYPE;
      illegal_op    = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = ALUB_FOUR;
            alu_op    = ALU_LW_SW;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b  = ALUB_BOFF;
            alu_op     = ALU_LW_SW;
            illegal_op = !is_legal(opcode);
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_RTYPE;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_JR: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_REGA;
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = ALUB_IMM;
            alu_op    = ALU_LW_SW;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_BRANCH;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
            branch_ne     = r_bne_q;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
         S_I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = ALUB_IMM;
            imm_zero  = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
            alu_op    = itype_alu_op(opcode);
         end
         S_I_WB: begin
            reg_write = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Self-checking bench for ctrl_multiciclo: per-instruction expected cycle sequences
// built from the instruction-level behaviour, directed cases then random programs.
module tb_ctrl_multiciclo;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       imm_zero;
      logic [1:0] pc_source;
      logic [3:0] alu_op;
      logic       illegal_op;
   } ov_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
   logic       reg_dst, mem_to_reg, reg_write, alu_src_a, imm_zero, illegal_op;
   logic [1:0] alu_src_b, pc_source;
   logic [3:0] alu_op;
   ov_t        obs;

   int n_checks = 0;
   int n_fail   = 0;

   ov_t   q_exp[$];
   logic  q_rdy[$];
   string q_tag[$];

   ctrl_multiciclo dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .branch_ne(branch_ne), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zero(imm_zero),
      .pc_source(pc_source), .alu_op(alu_op), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   assign obs = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
                 reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, imm_zero, pc_source,
                 alu_op, illegal_op};

   task automatic check_eq(input string tag, input ov_t got, input ov_t exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%06h expected 0x%06h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic op_legal(input logic [5:0] op);
      return (op == 6'h00) || (op == 6'h02) || (op == 6'h04) || (op == 6'h05) ||
             (op >= 6'h08 && op <= 6'h0F) || (op == 6'h23) || (op == 6'h2B);
   endfunction

   task automatic push(input ov_t e, input logic rdy, input string tag, input logic [5:0] op);
      q_exp.push_back(e);
      q_rdy.push_back(rdy);
      q_tag.push_back($sformatf("%s op=%02h", tag, op));
   endtask

   // Expected output sequence of one instruction; fs/ms are wait cycles in fetch/memory.
   task automatic plan(input logic [5:0] op, input logic [5:0] fn, input int fs, input int ms);
      ov_t e;
      logic [3:0] iop [8] = '{4'd1, 4'd1, 4'd6, 4'd7, 4'd3, 4'd4, 4'd5, 4'd8};
      e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'd1; e.alu_op = 4'd1;
      repeat (fs) push(e, 1'b0, "fetch_stall", op);
      e.ir_write = 1'b1; e.pc_write = 1'b1;
      push(e, 1'b1, "fetch", op);
      e = '0; e.alu_src_b = 2'd3; e.alu_op = 4'd1; e.illegal_op = !op_legal(op);
      push(e, rnd_bit(), "decode", op);
      if (op == 6'h00) begin
         e = '0; e.alu_src_a = 1'b1; e.alu_op = 4'd0;
         push(e, rnd_bit(), "r_exec", op);
         e = '0;
         if (fn == 6'h08) begin
            e.pc_write = 1'b1; e.pc_source = 2'd3;
            push(e, rnd_bit(), "jr", op);
         end else begin
            e.reg_write = 1'b1; e.reg_dst = 1'b1;
            push(e, rnd_bit(), "r_wb", op);
         end
      end else if (op == 6'h23 || op == 6'h2B) begin
         e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = 4'd1;
         push(e, rnd_bit(), "mem_addr", op);
         e = '0; e.i_or_d = 1'b1;
         if (op == 6'h23) e.mem_read = 1'b1;
         else             e.mem_write = 1'b1;
         repeat (ms) push(e, 1'b0, "mem_stall", op);
         push(e, 1'b1, "mem_access", op);
         if (op == 6'h23) begin
            e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
            push(e, rnd_bit(), "mem_wb", op);
         end
      end else if (op == 6'h04 || op == 6'h05) begin
         e = '0; e.alu_src_a = 1'b1; e.alu_op = 4'd2; e.pc_write_cond = 1'b1;
         e.pc_source = 2'd1; e.branch_ne = (op == 6'h05);
         push(e, rnd_bit(), "branch", op);
      end else if (op == 6'h02) begin
         e = '0; e.pc_write = 1'b1; e.pc_source = 2'd2;
         push(e, rnd_bit(), "jump", op);
      end else if (op >= 6'h08 && op <= 6'h0F) begin
         e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
         e.imm_zero = (op >= 6'h0C && op <= 6'h0E);
         e.alu_op = iop[op[2:0]];
         push(e, rnd_bit(), "i_exec", op);
         e = '0; e.reg_write = 1'b1;
         push(e, rnd_bit(), "i_wb", op);
      end
   endtask

   // Plays the planned cycles; opcode changes only once the new FETCH is underway.
   task automatic run(input logic [5:0] op, input logic [5:0] fn, input int limit);
      int n = 0;
      while (q_exp.size() > 0 && n < limit) begin
         @(negedge clk);
         if (n == 0) begin
            opcode = op;
            funct  = fn;
         end
         mem_ready = q_rdy.pop_front();
         zero      = rnd_bit();
         #1;
         check_eq(q_tag.pop_front(), obs, q_exp.pop_front());
         n++;
      end
      q_exp.delete();
      q_rdy.delete();
      q_tag.delete();
   endtask

   task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int fs, input int ms);
      plan(op, fn, fs, ms);
      run(op, fn, 1000);
   endtask

   initial begin
      logic [5:0] legal_ops [14] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                                     6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
      logic [5:0] op;
      logic [5:0] fn;
      rst_n = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1 check_eq("reset_hold", obs, ov_t'('0));
      @(negedge clk);
      rst_n = 1'b1;
      #1 check_eq("idle_after_reset", obs, ov_t'('0));

      do_instr(6'h00, 6'h20, 0, 0);     // ADD
      do_instr(6'h23, 6'h00, 0, 2);     // LW with two memory waits
      do_instr(6'h05, 6'h00, 0, 0);     // BNE
      do_instr(6'h04, 6'h00, 1, 0);     // BEQ after a fetch wait
      do_instr(6'h0D, 6'h00, 0, 0);     // ORI
      do_instr(6'h0F, 6'h00, 0, 0);     // LUI
      do_instr(6'h3F, 6'h00, 0, 0);     // illegal
      do_instr(6'h00, 6'h08, 0, 0);     // JR
      do_instr(6'h2B, 6'h00, 2, 1);     // SW with waits
      do_instr(6'h02, 6'h00, 0, 0);     // J

      // Abort an LW while it waits in the memory read phase.
      plan(6'h23, 6'h00, 0, 5);
      run(6'h23, 6'h00, 5);
      @(negedge clk);
      rst_n = 1'b0; mem_ready = 1'b0;
      #1 check_eq("reset_mid_mem_read", obs, ov_t'('0));
      @(negedge clk);
      rst_n = 1'b1; mem_ready = 1'b1;
      #1 check_eq("idle_after_abort", obs, ov_t'('0));
      do_instr(6'h09, 6'h00, 0, 0);     // ADDIU right after reset

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 13)];
         else                          op = 6'($urandom_range(0, 63));
         fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom_range(0, 63));
         do_instr(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
